// File: rtl/cache_line_fill_if.sv
// ---------------------------------------------------------------------------
// cache_line_fill_if
//   Groups the two handshakes of the line-fill unit: the miss-fill request
//   from the tag stage and the read-data beat stream from memory.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid and ready are both high; the source holds its payload stable
//   while valid is high and ready is low, and ready never depends on the
//   payload.
//
//   Signals (direction as seen by the fill unit, modport slave):
//     fill_req_valid_in   in   request valid
//     fill_req_addr_in    in   data-memory line index to fill
//     fill_req_ready_out  out  request accepted when valid & ready
//     beat_valid_in       in   read-data beat valid
//     beat_data_in        in   beat payload
//     beat_last_in        in   final-beat marker from the memory side
//     beat_ready_out      out  beat accepted when valid & ready
//   modport master is the request/memory side (the testbench).
// ---------------------------------------------------------------------------
interface cache_line_fill_if #(
   parameter int LINE_ADDR_WDTH = 6,
   parameter int BEAT_WDTH      = 128
);
   logic                      fill_req_valid_in;
   logic [LINE_ADDR_WDTH-1:0] fill_req_addr_in;
   logic                      fill_req_ready_out;
   logic                      beat_valid_in;
   logic [BEAT_WDTH-1:0]      beat_data_in;
   logic                      beat_last_in;
   logic                      beat_ready_out;

   modport master (
      output fill_req_valid_in, fill_req_addr_in,
      output beat_valid_in, beat_data_in, beat_last_in,
      input  fill_req_ready_out, beat_ready_out
   );

   modport slave (
      input  fill_req_valid_in, fill_req_addr_in,
      input  beat_valid_in, beat_data_in, beat_last_in,
      output fill_req_ready_out, beat_ready_out
   );
endinterface

// File: rtl/cache_line_fill.sv
// ---------------------------------------------------------------------------
// cache_line_fill
//   Assembles NUM_BEATS memory read beats into one cache line and writes it
//   into the data memory in a single cycle, stalling lookup reads while the
//   write owns the data-memory address port.
//
//   Optional feature: define FILL_LAST_CHECK_EN to check beat_last_in on
//   every accepted beat. A framing mismatch sets the sticky fill_err_out and
//   abandons the fill without writing. Undefined: beat_last_in is ignored and
//   the beat counter alone delimits the line.
//
//   Ports:
//     clk            in   clock, all state on the rising edge
//     rst_n          in   asynchronous active-low reset
//     fill_if        slave side of cache_line_fill_if (request + beats)
//     rd_addr_in     in   lookup-stage read address
//     addr_out       out  data-memory address (rd_addr_in unless writing)
//     w_data_out     out  data-memory write data (last assembled line)
//     w_en_out       out  data-memory write enable
//     rd_stall_out   out  lookup reads suppressed this cycle
//     fill_done_out  out  one-cycle pulse, line written
//     fill_err_out   out  sticky framing error
//     state_dbg_out  out  FSM state (0 IDLE, 1 COLLECT, 2 WRITE)
// ---------------------------------------------------------------------------
module cache_line_fill #(
   parameter int BIT_DEPTH       = 8,
   parameter int CACHE_LINE_WDTH = 48,
   parameter int SET_ADDR_WDTH   = 5,
   parameter int C_N_WAY         = 2,
   parameter int C_LG_BANKS      = 1,
   parameter int BEAT_WDTH       = 128,
   localparam int LINE_W         = BIT_DEPTH * CACHE_LINE_WDTH,
   localparam int LINE_ADDR_WDTH = SET_ADDR_WDTH + C_N_WAY - C_LG_BANKS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   cache_line_fill_if.slave          fill_if,
   input  logic [LINE_ADDR_WDTH-1:0] rd_addr_in,
   output logic [LINE_ADDR_WDTH-1:0] addr_out,
   output logic [LINE_W-1:0]         w_data_out,
   output logic                      w_en_out,
   output logic                      rd_stall_out,
   output logic                      fill_done_out,
   output logic                      fill_err_out,
   output logic [1:0]                state_dbg_out
);

   localparam int NUM_BEATS = LINE_W / BEAT_WDTH;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   generate
      if (LINE_W % BEAT_WDTH != 0) begin : g_bad_beat
         $error("line width must be a whole number of beats");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [LINE_ADDR_WDTH-1:0] addr_q, addr_d;
   logic [LINE_W-1:0]         line_q, line_d;
   logic [LINE_W-1:0]         hold_q, hold_d;
   logic                      err_q, err_d;

   logic req_acc;
   logic beat_acc;
   logic last_beat;
   logic frame_err;

   assign req_acc   = (state_q == IDLE) && fill_if.fill_req_valid_in;
   assign beat_acc  = (state_q == COLLECT) && fill_if.beat_valid_in;
   assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

`ifdef FILL_LAST_CHECK_EN
   // The memory's last marker must coincide exactly with the counter's view.
   assign frame_err = beat_acc && (fill_if.beat_last_in != last_beat);
`else
   logic unused_last;
   assign unused_last = fill_if.beat_last_in;
   assign frame_err   = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fill_if.fill_req_valid_in) state_d = COLLECT;
         COLLECT: if (beat_acc) begin
                     if (frame_err)      state_d = IDLE;
                     else if (last_beat) state_d = WRITE;
                  end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fill_if.fill_req_ready_out = 1'b0;
      fill_if.beat_ready_out     = 1'b0;
      w_en_out                   = 1'b0;
      rd_stall_out               = 1'b0;
      fill_done_out              = 1'b0;
      addr_out                   = rd_addr_in;
      w_data_out                 = hold_q;
      unique case (state_q)
         IDLE:    fill_if.fill_req_ready_out = 1'b1;
         COLLECT: fill_if.beat_ready_out     = 1'b1;
         WRITE: begin
            w_en_out      = 1'b1;
            rd_stall_out  = 1'b1;
            fill_done_out = 1'b1;
            addr_out      = addr_q;
            w_data_out    = line_q;
         end
         default: ;
      endcase
   end

   assign fill_err_out  = err_q;
   assign state_dbg_out = state_q;

   // ---------------- datapath next state ----------------
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      line_d = line_q;
      hold_d = hold_q;
      err_d  = err_q | frame_err;
      if (req_acc) begin
         addr_d = fill_if.fill_req_addr_in;
         cnt_d  = '0;
      end
      if (beat_acc) begin
         cnt_d = cnt_q + CNT_W'(1);
         // Beat k lands in slice k, beat 0 lowest.
         for (int k = 0; k < NUM_BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) line_d[k*BEAT_WDTH +: BEAT_WDTH] = fill_if.beat_data_in;
         end
      end
      // w_data_out keeps showing the written line while the next fill assembles.
      if (state_q == WRITE) hold_d = line_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         addr_q <= '0;
         line_q <= '0;
         hold_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         line_q <= line_d;
         hold_q <= hold_d;
         err_q  <= err_d;
      end
   end

endmodule
